// File: rtl/bot_wb_arbiter_if.sv
// Bus bundle for the two-master Wishbone arbiter in front of the rojobot register slave.
// The arbiter takes the slave modport; masters and the register slave sit on the master modport.
interface bot_wb_arbiter_if;
  logic [31:0] m0_adr_i;
  logic [31:0] m1_adr_i;
  logic [31:0] m0_dat_i;
  logic [31:0] m1_dat_i;
  logic [3:0]  m0_sel_i;
  logic [3:0]  m1_sel_i;
  logic        m0_we_i;
  logic        m0_cyc_i;
  logic        m0_stb_i;
  logic        m1_we_i;
  logic        m1_cyc_i;
  logic        m1_stb_i;
  logic [31:0] m0_dat_o;
  logic [31:0] m1_dat_o;
  logic        m0_ack_o;
  logic        m0_err_o;
  logic        m1_ack_o;
  logic        m1_err_o;
  logic [31:0] s_adr_o;
  logic [31:0] s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o;
  logic        s_cyc_o;
  logic        s_stb_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;
  logic        s_err_i;
  logic [1:0]  gnt_o;

  modport slave (
    input  m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, m0_sel_i, m1_sel_i,
    input  m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i,
    input  s_dat_i, s_ack_i, s_err_i,
    output m0_dat_o, m1_dat_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    output gnt_o
  );

  modport master (
    output m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, m0_sel_i, m1_sel_i,
    output m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i,
    output s_dat_i, s_ack_i, s_err_i,
    input  m0_dat_o, m1_dat_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    input  gnt_o
  );
endinterface

// File: rtl/bot_wb_arbiter.sv
// Round-robin, non-preemptive arbiter sharing the rojobot register slave between two
// Wishbone masters, with a stall watchdog that terminates hung cycles with an error.
module bot_wb_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  bot_wb_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t     state_r;
  state_t     state_next_s;
  logic       last_owner_r;
  logic       last_owner_next_s;
  logic [7:0] wdog_r;
  logic [7:0] wdog_next_s;
  logic [1:0] gnt_r;

  logic       own_s;
  logic       sel1_s;
  logic       cur_cyc_s;
  logic       cur_stb_s;
  logic       timeout_s;

  function automatic logic [1:0] gnt_decode(input state_t st);
    logic [1:0] g;
    case (st)
      OWN0:    g = 2'b01;
      OWN1:    g = 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

  // Select the owning master's control strobes.
  always_comb begin
    own_s     = 1'b0;
    sel1_s    = 1'b0;
    cur_cyc_s = 1'b0;
    cur_stb_s = 1'b0;
    case (state_r)
      OWN0: begin
        own_s     = 1'b1;
        sel1_s    = 1'b0;
        cur_cyc_s = bus.m0_cyc_i;
        cur_stb_s = bus.m0_stb_i;
      end
      OWN1: begin
        own_s     = 1'b1;
        sel1_s    = 1'b1;
        cur_cyc_s = bus.m1_cyc_i;
        cur_stb_s = bus.m1_stb_i;
      end
      default: begin
        own_s     = 1'b0;
        sel1_s    = 1'b0;
        cur_cyc_s = 1'b0;
        cur_stb_s = 1'b0;
      end
    endcase
  end

  // A slave ack in the expiry cycle takes precedence over the forced error.
  assign timeout_s = own_s && (wdog_r == TIMEOUT_C) && !bus.s_ack_i;

  // Next-state, round-robin tie-break and watchdog update.
  always_comb begin
    state_next_s      = state_r;
    last_owner_next_s = last_owner_r;
    wdog_next_s       = wdog_r;
    case (state_r)
      IDLE: begin
        wdog_next_s = 8'd0;
        if (bus.m0_cyc_i && bus.m1_cyc_i) begin
          if (last_owner_r) begin
            state_next_s      = OWN0;
            last_owner_next_s = 1'b0;
          end else begin
            state_next_s      = OWN1;
            last_owner_next_s = 1'b1;
          end
        end else if (bus.m0_cyc_i) begin
          state_next_s      = OWN0;
          last_owner_next_s = 1'b0;
        end else if (bus.m1_cyc_i) begin
          state_next_s      = OWN1;
          last_owner_next_s = 1'b1;
        end else begin
          state_next_s      = IDLE;
          last_owner_next_s = last_owner_r;
        end
      end
      OWN0, OWN1: begin
        if (bus.s_ack_i || bus.s_err_i || !cur_stb_s || timeout_s) begin
          wdog_next_s = 8'd0;
        end else if (wdog_r != 8'hFF) begin
          wdog_next_s = wdog_r + 8'd1;
        end else begin
          wdog_next_s = wdog_r;
        end
        if (!cur_cyc_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: begin
        state_next_s = IDLE;
        wdog_next_s  = 8'd0;
      end
    endcase
  end

  // State, owner history, watchdog and grant registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      last_owner_r <= 1'b1;
      wdog_r       <= 8'd0;
      gnt_r        <= 2'b00;
    end else begin
      state_r      <= state_next_s;
      last_owner_r <= last_owner_next_s;
      wdog_r       <= wdog_next_s;
      gnt_r        <= gnt_decode(state_next_s);
    end
  end

  assign bus.gnt_o = gnt_r;

  // Route the owner to the slave and the slave's response back to the owner only.
  always_comb begin
    bus.s_adr_o  = 32'd0;
    bus.s_dat_o  = 32'd0;
    bus.s_sel_o  = 4'd0;
    bus.s_we_o   = 1'b0;
    bus.s_cyc_o  = 1'b0;
    bus.s_stb_o  = 1'b0;
    bus.m0_dat_o = 32'd0;
    bus.m0_ack_o = 1'b0;
    bus.m0_err_o = 1'b0;
    bus.m1_dat_o = 32'd0;
    bus.m1_ack_o = 1'b0;
    bus.m1_err_o = 1'b0;
    if (!reset && own_s) begin
      bus.s_cyc_o = cur_cyc_s && !timeout_s;
      bus.s_stb_o = cur_stb_s && !timeout_s;
      if (sel1_s) begin
        bus.s_adr_o  = bus.m1_adr_i;
        bus.s_dat_o  = bus.m1_dat_i;
        bus.s_sel_o  = bus.m1_sel_i;
        bus.s_we_o   = bus.m1_we_i;
        bus.m1_dat_o = bus.s_dat_i;
        bus.m1_ack_o = bus.s_ack_i && !timeout_s;
        bus.m1_err_o = bus.s_err_i || timeout_s;
      end else begin
        bus.s_adr_o  = bus.m0_adr_i;
        bus.s_dat_o  = bus.m0_dat_i;
        bus.s_sel_o  = bus.m0_sel_i;
        bus.s_we_o   = bus.m0_we_i;
        bus.m0_dat_o = bus.s_dat_i;
        bus.m0_ack_o = bus.s_ack_i && !timeout_s;
        bus.m0_err_o = bus.s_err_i || timeout_s;
      end
    end else begin
      bus.s_cyc_o = 1'b0;
      bus.s_stb_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_bot_wb_arbiter.sv
// Self-checking bench for bot_wb_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_bot_wb_arbiter;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bot_wb_arbiter_if bus();

  bot_wb_arbiter #(.TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] adr  [2];
  logic [31:0] wdat [2];
  logic [3:0]  sel  [2];
  logic        we   [2];
  logic        cyc  [2];
  logic        stb  [2];
  logic [31:0] sdat;
  logic        sack;
  logic        serr;

  assign bus.m0_adr_i = adr[0];
  assign bus.m1_adr_i = adr[1];
  assign bus.m0_dat_i = wdat[0];
  assign bus.m1_dat_i = wdat[1];
  assign bus.m0_sel_i = sel[0];
  assign bus.m1_sel_i = sel[1];
  assign bus.m0_we_i  = we[0];
  assign bus.m1_we_i  = we[1];
  assign bus.m0_cyc_i = cyc[0];
  assign bus.m1_cyc_i = cyc[1];
  assign bus.m0_stb_i = stb[0];
  assign bus.m1_stb_i = stb[1];
  assign bus.s_dat_i  = sdat;
  assign bus.s_ack_i  = sack;
  assign bus.s_err_i  = serr;

  wire [140:0] dut_v = {bus.gnt_o, bus.s_adr_o, bus.s_dat_o, bus.s_sel_o, bus.s_we_o,
                        bus.s_cyc_o, bus.s_stb_o, bus.m0_dat_o, bus.m0_ack_o, bus.m0_err_o,
                        bus.m1_dat_o, bus.m1_ack_o, bus.m1_err_o};

  int n_checks = 0;
  int n_errors = 0;

  // Model: owner is -1 when nobody holds the bus; stall counts consecutive unanswered strobes.
  int m_owner = -1;
  int m_last  = 1;
  int m_stall = 0;

  function automatic logic model_timeout();
    return (m_owner >= 0) && (m_stall == TMO) && !sack;
  endfunction

  function automatic logic [140:0] exp_v();
    logic [1:0]  g;
    logic [31:0] sa, sd, d0, d1;
    logic [3:0]  ss;
    logic        sw, sc, st, a0, e0, a1, e1, to;
    g  = (m_owner == 0) ? 2'b01 : ((m_owner == 1) ? 2'b10 : 2'b00);
    sa = 32'd0; sd = 32'd0; d0 = 32'd0; d1 = 32'd0; ss = 4'd0;
    sw = 1'b0; sc = 1'b0; st = 1'b0; a0 = 1'b0; e0 = 1'b0; a1 = 1'b0; e1 = 1'b0;
    to = model_timeout();
    if (!reset && m_owner >= 0) begin
      sa = adr[m_owner];
      sd = wdat[m_owner];
      ss = sel[m_owner];
      sw = we[m_owner];
      sc = cyc[m_owner] && !to;
      st = stb[m_owner] && !to;
      if (m_owner == 0) begin
        d0 = sdat; a0 = sack; e0 = serr || to;
      end else begin
        d1 = sdat; a1 = sack; e1 = serr || to;
      end
    end
    return {g, sa, sd, ss, sw, sc, st, d0, a0, e0, d1, a1, e1};
  endfunction

  task automatic model_step();
    logic to;
    if (reset) begin
      m_owner = -1;
      m_last  = 1;
      m_stall = 0;
    end else if (m_owner < 0) begin
      m_stall = 0;
      if (cyc[0] && cyc[1]) m_owner = 1 - m_last;
      else if (cyc[0])      m_owner = 0;
      else if (cyc[1])      m_owner = 1;
      if (m_owner >= 0) m_last = m_owner;
    end else begin
      to = model_timeout();
      if (sack || serr || !stb[m_owner] || to) m_stall = 0;
      else if (m_stall < 255)                  m_stall = m_stall + 1;
      if (!cyc[m_owner]) m_owner = -1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive_idle();
    for (int k = 0; k < 2; k++) begin
      adr[k] = 32'd0; wdat[k] = 32'd0; sel[k] = 4'd0;
      we[k] = 1'b0; cyc[k] = 1'b0; stb[k] = 1'b0;
    end
    sdat = 32'd0; sack = 1'b0; serr = 1'b0;
  endtask

  task automatic apply_reset();
    drive_idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      adr[k] = $urandom; wdat[k] = $urandom; sel[k] = 4'hF;
      we[k] = 1'b1; cyc[k] = 1'b1; stb[k] = 1'b1;
    end
    sdat = $urandom; sack = 1'b1; serr = 1'b1;
    tick();
    #1;
    n_checks++;
    if (bus.gnt_o !== 2'b00) begin
      n_errors++; $display("FAIL reset_gnt: got %b expected 00", bus.gnt_o);
    end
    n_checks++;
    if (dut_v !== 141'd0) begin
      n_errors++; $display("FAIL reset_outputs: got %h expected all zero", dut_v);
    end
    drive_idle();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_m0_write();
    apply_reset();
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1;
    adr[0] = 32'h0000_0010; wdat[0] = 32'h0000_00A5; sel[0] = 4'hF;
    #1;
    n_checks++;
    if (bus.gnt_o !== 2'b00 || bus.s_cyc_o !== 1'b0) begin
      n_errors++; $display("FAIL m0w_latency: gnt=%b s_cyc=%b expected 00/0", bus.gnt_o, bus.s_cyc_o);
    end
    tick();
    n_checks++;
    if (bus.gnt_o !== 2'b01) begin
      n_errors++; $display("FAIL m0w_gnt: got %b expected 01", bus.gnt_o);
    end
    n_checks++;
    if (bus.s_adr_o !== 32'h10 || bus.s_dat_o !== 32'hA5 || bus.s_we_o !== 1'b1 || bus.s_stb_o !== 1'b1) begin
      n_errors++; $display("FAIL m0w_fwd: adr=%h dat=%h we=%b stb=%b expected 10/a5/1/1",
                           bus.s_adr_o, bus.s_dat_o, bus.s_we_o, bus.s_stb_o);
    end
    sack = 1'b1;
    #1;
    n_checks++;
    if (bus.m0_ack_o !== 1'b1 || bus.m1_ack_o !== 1'b0) begin
      n_errors++; $display("FAIL m0w_ack: m0_ack=%b m1_ack=%b expected 1/0", bus.m0_ack_o, bus.m1_ack_o);
    end
    tick();
    drive_idle();
    tick();
    n_checks++;
    if (bus.gnt_o !== 2'b00) begin
      n_errors++; $display("FAIL m0w_release: got %b expected 00", bus.gnt_o);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [5];
    exp_g[0] = 2'b01; exp_g[1] = 2'b00; exp_g[2] = 2'b10; exp_g[3] = 2'b00; exp_g[4] = 2'b01;
    apply_reset();
    for (int s = 0; s < 5; s++) begin
      case (s)
        0: begin cyc[0] = 1'b1; cyc[1] = 1'b1; end
        1: cyc[0] = 1'b0;
        2: cyc[0] = 1'b0;
        3: cyc[1] = 1'b0;
        default: begin cyc[0] = 1'b1; cyc[1] = 1'b1; end
      endcase
      stb[0] = cyc[0]; stb[1] = cyc[1];
      tick();
      n_checks++;
      if (bus.gnt_o !== exp_g[s]) begin
        n_errors++; $display("FAIL rr_step%0d: got %b expected %b", s, bus.gnt_o, exp_g[s]);
      end
    end
    drive_idle();
    tick();
  endtask

  task automatic test_m1_read();
    apply_reset();
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h0000_000C; sel[1] = 4'hF;
    sdat = 32'h1234_5678;
    tick();
    n_checks++;
    if (bus.gnt_o !== 2'b10 || bus.s_adr_o !== 32'h0C || bus.s_we_o !== 1'b0) begin
      n_errors++; $display("FAIL m1r_grant: gnt=%b adr=%h we=%b expected 10/0c/0",
                           bus.gnt_o, bus.s_adr_o, bus.s_we_o);
    end
    sack = 1'b1;
    #1;
    n_checks++;
    if (bus.m1_dat_o !== 32'h1234_5678 || bus.m1_ack_o !== 1'b1) begin
      n_errors++; $display("FAIL m1r_data: dat=%h ack=%b expected 12345678/1", bus.m1_dat_o, bus.m1_ack_o);
    end
    n_checks++;
    if (bus.m0_dat_o !== 32'd0 || bus.m0_ack_o !== 1'b0 || bus.m0_err_o !== 1'b0) begin
      n_errors++; $display("FAIL m1r_m0quiet: dat=%h ack=%b err=%b expected 0/0/0",
                           bus.m0_dat_o, bus.m0_ack_o, bus.m0_err_o);
    end
    tick();
    drive_idle();
    tick();
  endtask

  task automatic test_timeout();
    logic exp_err;
    apply_reset();
    cyc[0] = 1'b1; stb[0] = 1'b1;
    tick();
    for (int c = 1; c <= 10; c++) begin
      exp_err = (c == 5) || (c == 10);
      n_checks++;
      if (bus.m0_err_o !== exp_err || bus.s_stb_o !== !exp_err || bus.m0_ack_o !== 1'b0) begin
        n_errors++; $display("FAIL timeout_cycle%0d: err=%b stb=%b ack=%b expected %b/%b/0",
                             c, bus.m0_err_o, bus.s_stb_o, bus.m0_ack_o, exp_err, !exp_err);
      end
      tick();
    end
    n_checks++;
    if (bus.gnt_o !== 2'b01) begin
      n_errors++; $display("FAIL timeout_holds_owner: got %b expected 01", bus.gnt_o);
    end
    drive_idle();
    tick();
    tick();
  endtask

  task automatic test_ack_wins();
    apply_reset();
    cyc[0] = 1'b1; stb[0] = 1'b1;
    tick();
    for (int c = 1; c <= 10; c++) begin
      sack = (c == 5);
      #1;
      n_checks++;
      if (c == 5) begin
        if (bus.m0_ack_o !== 1'b1 || bus.m0_err_o !== 1'b0) begin
          n_errors++; $display("FAIL ackwin_tie: ack=%b err=%b expected 1/0", bus.m0_ack_o, bus.m0_err_o);
        end
      end else if (bus.m0_err_o !== (c == 10)) begin
        n_errors++; $display("FAIL ackwin_cycle%0d: err=%b expected %b", c, bus.m0_err_o, (c == 10));
      end
      tick();
    end
    drive_idle();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cyc[1] = 1'b1; stb[1] = 1'b1;
    tick();
    n_checks++;
    if (bus.gnt_o !== 2'b10 || bus.s_cyc_o !== 1'b1) begin
      n_errors++; $display("FAIL rstmid_owned: gnt=%b s_cyc=%b expected 10/1", bus.gnt_o, bus.s_cyc_o);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if (bus.gnt_o !== 2'b00 || bus.s_cyc_o !== 1'b0 || bus.m1_err_o !== 1'b0) begin
      n_errors++; $display("FAIL rstmid_abort: gnt=%b s_cyc=%b err=%b expected 00/0/0",
                           bus.gnt_o, bus.s_cyc_o, bus.m1_err_o);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (bus.gnt_o !== 2'b10) begin
      n_errors++; $display("FAIL rstmid_regrant: got %b expected 10", bus.gnt_o);
    end
    drive_idle();
    tick();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      for (int k = 0; k < 2; k++) begin
        adr[k]  = $urandom;
        wdat[k] = $urandom;
        sel[k]  = 4'($urandom_range(15, 0));
        we[k]   = 1'($urandom_range(1, 0));
        if ($urandom_range(99, 0) < 20) cyc[k] = !cyc[k];
        stb[k]  = ($urandom_range(99, 0) < 85);
      end
      sdat  = $urandom;
      sack  = ($urandom_range(99, 0) < 12);
      serr  = ($urandom_range(99, 0) < 3);
      reset = ($urandom_range(199, 0) == 0);
      #1;
      n_checks++;
      if (dut_v !== exp_v()) begin
        n_errors++; $display("FAIL random_cycle%0d: got %h expected %h", i, dut_v, exp_v());
      end
      tick();
    end
    reset = 1'b0;
    drive_idle();
    tick();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_m0_write();
    test_round_robin();
    test_m1_read();
    test_timeout();
    test_ack_wins();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bot_wb_arbiter.md
BOT_WB_ARBITER -- requirements
Module: bot_wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning slave-stall cycles before a forced error; legal range 1..255.
REQ-002 SHALL have port clk, input, 1, system clock; one clock, all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have ports m0_adr_i / m1_adr_i, input, 32 each, master address.
REQ-005 SHALL have ports m0_dat_i / m1_dat_i, input, 32 each, master write data.
REQ-006 SHALL have ports m0_sel_i / m1_sel_i, input, 4 each, byte selects.
REQ-007 SHALL have ports m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i, input, 1 each, Wishbone controls.
REQ-008 SHALL have ports m0_dat_o / m1_dat_o, output, 32 each, read data.
REQ-009 SHALL have ports m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, output, 1 each, termination.
REQ-010 SHALL have ports s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, output, 32/32/4/1/1/1, to the rojobot register slave.
REQ-011 SHALL have ports s_dat_i, s_ack_i, s_err_i, input, 32/1/1, from the slave.
REQ-012 SHALL have port gnt_o, output, 2, one-hot current owner (bit0 = m0, bit1 = m1, 00 = idle).

Function
REQ-013 SHALL implement FSM states IDLE, OWN0, OWN1, held in a register.
REQ-014 SHALL keep a 1-bit last_owner register recording the master most recently granted.
REQ-015 In IDLE, SHALL go to OWN0 if only m0_cyc_i is high, or to OWN1 if only m1_cyc_i is high, on the next edge.
REQ-016 In IDLE with both cyc high, SHALL grant the master that is not last_owner (round-robin).
REQ-017 On entering OWNx, SHALL set last_owner to x.
REQ-018 In OWNx, SHALL return to IDLE on the edge where mx_cyc_i is sampled low.
REQ-019 SHALL hold ownership while mx_cyc_i stays high; no preemption.
REQ-020 SHALL insert one IDLE cycle between consecutive grants, so the minimum cyc-to-grant latency is 1 cycle.
REQ-021 In OWNx, s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o and s_stb_o SHALL combinationally equal master x inputs.
REQ-022 In OWNx, mx_dat_o, mx_ack_o and mx_err_o SHALL combinationally follow s_dat_i, s_ack_i and s_err_i.
REQ-023 In IDLE, s_cyc_o and s_stb_o SHALL be 0, and all other s_* outputs SHALL be 0.
REQ-024 The non-owning master SHALL see dat_o = 0, ack_o = 0, err_o = 0 at all times.
REQ-025 SHALL have an 8-bit watchdog counter.
- Clears on entering OWNx, on any s_ack_i or s_err_i, and whenever mx_stb_i is low.
- Otherwise increments each cycle in OWNx, saturating at 255.
REQ-026 When the watchdog equals TIMEOUT in OWNx, for that one cycle:
- mx_err_o SHALL be 1.
- mx_ack_o SHALL be 0.
- s_cyc_o and s_stb_o SHALL be forced to 0.
- The counter SHALL clear on the next edge.
REQ-027 A timeout SHALL leave the state in OWNx; release still follows REQ-018.
REQ-028 If s_ack_i and the timeout coincide, ack SHALL win: no err, and the counter clears.
REQ-029 gnt_o SHALL be registered and decoded from state: OWN0 gives 01, OWN1 gives 10, IDLE gives 00.

Reset
REQ-030 With reset high at a clock edge, the block SHALL set state = IDLE, last_owner = 1 (so m0 wins the first tie), watchdog = 0 and gnt_o = 00.
REQ-031 During reset, all s_* outputs and all m* ack/err/dat outputs SHALL be 0.
REQ-032 Reset asserted mid-transfer SHALL abort the grant at that edge with no err pulse; the master is responsible for dropping cyc.

Verification
REQ-033 Reset release, then m0 cyc/stb/we high, adr=0x10, dat=0x0000_00A5:
- gnt_o = 01 one cycle later.
- s_adr_o = 0x10, s_dat_o = 0xA5 that cycle.
- Slave ack is forwarded to m0_ack_o only.
REQ-034 Both cyc rise on the same edge right after reset:
- Sequence is OWN0, then IDLE after m0 drops cyc, then OWN1.
- A second simultaneous request after that grants m0 again (alternation 01,10,01).
REQ-035 m1 owns the bus and reads 0x0C while the slave returns s_dat_i = 0x1234_5678 with ack:
- m1_dat_o = 0x1234_5678.
- m0_dat_o = 0 and m0_ack_o = 0 throughout.
REQ-036 TIMEOUT = 4, m0 stb held, slave never acks:
- m0_err_o pulses exactly on the 5th cycle of OWN0 (watchdog = 4), with s_stb_o = 0 that cycle.
- The next pulse comes 5 cycles later if stb is still held.
REQ-037 TIMEOUT = 4, s_ack_i arrives on the same cycle the watchdog reaches 4:
- m0_ack_o = 1, m0_err_o = 0.
- The watchdog reads 0 on the next cycle.
REQ-038 Reset pulsed while in OWN1 with m1 cyc still high:
- gnt_o = 00 and s_cyc_o = 0 on the reset edge.
- After reset deasserts, m1 is regranted (gnt_o = 10) one cycle later.
